// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one backing-memory port between the L1 I-cache and D-cache
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   ic_req_i, ic_addr_i              I-cache read request and address
//   ic_ready_o, ic_rdata_o, ic_err_o I-cache completion pulse, read data, timeout flag
//   dc_req_i, dc_we_i, dc_addr_i,
//   dc_wdata_i                       D-cache request, write enable, address, write data
//   dc_ready_o, dc_rdata_o, dc_err_o D-cache completion pulse, read data, timeout flag
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                      memory request and latched command
//   mem_ready_i, mem_rdata_i         memory completion and read data
module l1_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ready_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_err_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_ready_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e state_q, state_d;
  logic owner_q, last_q, err_q, we_q;
  logic [CW-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ic_rdata_q, dc_rdata_q;
  logic any_req, grant_dc, timeout, done;
  // owner/last encode the requester: 0 = I-cache, 1 = D-cache
  assign any_req  = ic_req_i | dc_req_i;
  assign grant_dc = (ic_req_i & dc_req_i) ? ~last_q : dc_req_i;
  assign timeout  = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // a response arriving on the last allowed cycle still counts as a normal completion
  assign done     = mem_ready_i | timeout;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q <= grant_dc;
        last_q  <= grant_dc;
        we_q    <= grant_dc & dc_we_i;
        addr_q  <= grant_dc ? dc_addr_i : ic_addr_i;
        wdata_q <= grant_dc ? dc_wdata_i : '0;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end
      if (state_q == BUSY) begin
        cnt_q <= cnt_q + CW'(1);
        if (done) begin
          err_q <= ~mem_ready_i;
          if (owner_q) dc_rdata_q <= mem_ready_i ? mem_rdata_i : ERR_DATA;
          else ic_rdata_q <= mem_ready_i ? mem_rdata_i : ERR_DATA;
        end
      end
      if (state_q == RESP) cnt_q <= '0;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = any_req ? BUSY : IDLE;
      BUSY:    state_d = done ? RESP : BUSY;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_req_o   = state_q == BUSY;
    mem_we_o    = we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    ic_ready_o  = state_q == RESP && !owner_q;
    dc_ready_o  = state_q == RESP && owner_q;
    ic_err_o    = ic_ready_o & err_q;
    dc_err_o    = dc_ready_o & err_q;
    ic_rdata_o  = ic_rdata_q;
    dc_rdata_o  = dc_rdata_q;
  end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed self-checking bench for l1_mem_arbiter (TIMEOUT_CYCLES=8)
module tb_l1_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0, mem_rdata = '0;
  logic ic_ready, ic_err, dc_ready, dc_err, mem_req, mem_we;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  int errors = 0, checks = 0;
  l1_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_ready_o(ic_ready), .ic_rdata_o(ic_rdata), .ic_err_o(ic_err),
    .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_ready_o(dc_ready), .dc_rdata_o(dc_rdata), .dc_err_o(dc_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_ready(input string tag, input logic icr, input logic ice, input logic dcr, input logic dce);
    chk({tag, "_ic_ready"}, {31'd0, ic_ready}, {31'd0, icr});
    chk({tag, "_ic_err"}, {31'd0, ic_err}, {31'd0, ice});
    chk({tag, "_dc_ready"}, {31'd0, dc_ready}, {31'd0, dcr});
    chk({tag, "_dc_err"}, {31'd0, dc_err}, {31'd0, dce});
  endtask
  initial begin
    tick();
    chk_ready("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ic_rdata", ic_rdata, 32'd0);
    chk("rst_dc_rdata", dc_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    // IC read, memory answers on the second BUSY edge
    ic_req = 1'b1; ic_addr = 32'h0000_0802;
    tick();
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h0000_0802);
    chk_ready("t1_busy", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t1_mem_req_hold", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    tick();
    chk_ready("t1_resp", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_ic_rdata", ic_rdata, 32'hAAAA_AAAA);
    chk("t1_mem_req_drop", {31'd0, mem_req}, 32'd0);
    ic_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk_ready("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_ic_rdata_hold", ic_rdata, 32'hAAAA_AAAA);
    // DC write; command inputs change after grant
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'hABCD_E832; dc_wdata = 32'hBEEF_DEAD;
    tick();
    chk("t2_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2_mem_addr", mem_addr, 32'hABCD_E832);
    chk("t2_mem_wdata", mem_wdata, 32'hBEEF_DEAD);
    dc_addr = 32'h0; dc_wdata = 32'h0; dc_we = 1'b0;
    tick();
    chk("t6_mem_addr_stable", mem_addr, 32'hABCD_E832);
    chk("t2_mem_wdata_stable", mem_wdata, 32'hBEEF_DEAD);
    chk("t2_mem_we_stable", {31'd0, mem_we}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk_ready("t2_resp", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_ic_rdata_unchanged", ic_rdata, 32'hAAAA_AAAA);
    dc_req = 1'b0; mem_ready = 1'b0;
    tick();
    // reset in the middle of an IC transaction
    ic_req = 1'b1; ic_addr = 32'h0000_0100;
    tick();
    chk("t5_mem_req_busy", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_req_async_drop", {31'd0, mem_req}, 32'd0);
    ic_req = 1'b0;
    tick();
    chk_ready("t5_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_ready("t5_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    // simultaneous requests after reset: DC, then IC, then DC
    ic_req = 1'b1; ic_addr = 32'h0000_0200;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0300;
    tick();
    chk("t3_tie1_addr", mem_addr, 32'h0000_0300);
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    chk_ready("t3_tie1_resp", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_dc_rdata", dc_rdata, 32'h1111_1111);
    dc_req = 1'b0; mem_ready = 1'b0;
    tick();
    dc_req = 1'b1;
    tick();
    chk("t3_tie2_addr", mem_addr, 32'h0000_0200);
    chk("t3_tie2_we", {31'd0, mem_we}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    chk_ready("t3_tie2_resp", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_ic_rdata", ic_rdata, 32'h2222_2222);
    chk("t3_dc_rdata_hold", dc_rdata, 32'h1111_1111);
    ic_req = 1'b0; mem_ready = 1'b0;
    tick();
    ic_req = 1'b1;
    tick();
    chk("t3_tie3_addr", mem_addr, 32'h0000_0300);
    // that DC read now times out: 8 BUSY cycles with no mem_ready
    for (int i = 0; i < 7; i++) tick();
    chk("t4_mem_req_last_busy", {31'd0, mem_req}, 32'd1);
    chk_ready("t4_last_busy", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ready("t4_timeout", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_dc_rdata_err", dc_rdata, 32'hDEAD_BEEF);
    chk("t4_mem_req_drop", {31'd0, mem_req}, 32'd0);
    dc_req = 1'b0;
    tick();
    chk_ready("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4_next_addr", mem_addr, 32'h0000_0200);
    chk("t4_next_mem_req", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    chk_ready("t4_next_resp", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_next_ic_rdata", ic_rdata, 32'h3333_3333);
    ic_req = 1'b0; mem_ready = 1'b0;
    tick();
    // spurious mem_ready while idle
    mem_ready = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    chk_ready("t6_spur1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ready("t6_spur2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_ic_rdata", ic_rdata, 32'h3333_3333);
    chk("t6_dc_rdata", dc_rdata, 32'hDEAD_BEEF);
    mem_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
